// File: rtl/mc_controller.sv
// Multicycle MIPS-subset main controller: Moore FSM sequencing the shared datapath.
// Optional bne support is built when MC_CONTROLLER_BNE_EN is defined.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_CONTROLLER_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e state_q, state_d;
    // Load/store direction is captured in DECODE so later opcode changes cannot redirect MEMADR.
    logic   is_sw_q, is_sw_d;
    logic   pcwrite, branch, branch_not;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_sw_d    = is_sw_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_not = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_CONTROLLER_BNE_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                branch_not = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Branch outcome uses the zero flag of this same cycle, hence combinational.
        pcen = pcwrite | (branch & (zero ^ branch_not));
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-instruction phase lists expanded from the
// instruction-level cycle rules, each cycle's outputs compared against an output table.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MW, P_MWR, P_RX, P_RW, P_B, P_BN, P_AX, P_AW, P_J} ph_e;

    wire [16:0] obs = {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
                       alusrcb, pcsrc, alucontrol};

    // Expected output bundle for one phase; unlisted outputs are 0 and the ALU adds.
    function automatic logic [16:0] exp_out(ph_e p, logic [5:0] fn, logic z);
        logic pc, irw, rw, mw, asa, io, m2r, rd;
        logic [1:0] asb, ps;
        logic [2:0] ac;
        {pc, irw, rw, mw, asa, io, m2r, rd} = 8'h00;
        asb = 2'b00; ps = 2'b00; ac = 3'b010;
        case (p)
            P_F:   begin asb = 2'b01; irw = 1; pc = 1; end
            P_D:   asb = 2'b11;
            P_MA:  begin asa = 1; asb = 2'b10; end
            P_MR:  io = 1;
            P_MW:  begin m2r = 1; rw = 1; end
            P_MWR: begin io = 1; mw = 1; end
            P_RX: begin
                asa = 1;
                if      (fn == 6'b100010) ac = 3'b110;
                else if (fn == 6'b100100) ac = 3'b000;
                else if (fn == 6'b100101) ac = 3'b001;
                else if (fn == 6'b101010) ac = 3'b111;
            end
            P_RW:  begin rd = 1; rw = 1; end
            P_B:   begin asa = 1; ac = 3'b110; ps = 2'b01; pc = z; end
            P_BN:  begin asa = 1; ac = 3'b110; ps = 2'b01; pc = ~z; end
            P_AX:  begin asa = 1; asb = 2'b10; end
            P_AW:  rw = 1;
            P_J:   begin ps = 2'b10; pc = 1; end
            default: ;
        endcase
        return {pc, irw, rw, mw, asa, io, m2r, rd, asb, ps, ac};
    endfunction

    task automatic check(input string tag, input logic [16:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Runs one instruction from FETCH (or from DECODE), one check per cycle.
    // zmode <0 randomizes zero; abort_at >=0 pulses reset inside that phase index.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit from_decode,
                             input int zmode, input int abort_at, input string tag);
        ph_e q[$];
        if (!from_decode) q.push_back(P_F);
        q.push_back(P_D);
        case (op)
            6'b100011: begin q.push_back(P_MA); q.push_back(P_MR); q.push_back(P_MW); end
            6'b101011: begin q.push_back(P_MA); q.push_back(P_MWR); end
            6'b000000: begin q.push_back(P_RX); q.push_back(P_RW); end
            6'b000100: q.push_back(P_B);
            6'b001000: begin q.push_back(P_AX); q.push_back(P_AW); end
            6'b000010: q.push_back(P_J);
`ifdef MC_CONTROLLER_BNE_EN
            6'b000101: q.push_back(P_BN);
`endif
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            opcode = (q[i] == P_D)  ? op : 6'($urandom);
            funct  = (q[i] == P_RX) ? fn : 6'($urandom);
            zero   = (zmode < 0) ? 1'($urandom) : zmode[0];
            #1;
            check(tag, exp_out(q[i], fn, zero));
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_abort"}, exp_out(P_F, fn, zero));
                reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] op_tab [0:8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                 6'b000010, 6'b000101, 6'b111111, 6'b010101};
    logic [5:0] fn_tab [0:6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b111111, 6'b000000};

    initial begin
        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'b0;
        zero   = 1'b0;
        #2;
        check("reset_hold", exp_out(P_F, funct, zero));
        repeat (2) begin
            @(posedge clk); #1;
            opcode = 6'($urandom); zero = 1'($urandom);
            #1;
            check("reset_hold_edge", exp_out(P_F, funct, zero));
        end
        reset = 1'b0;

        run_instr(6'b100011, 6'h00, 0, -1, -1, "lw");
        run_instr(6'b101011, 6'h00, 0, -1, -1, "sw");
        run_instr(6'b000000, 6'b101010, 0, -1, -1, "rtype_slt");
        run_instr(6'b000000, 6'b111111, 0, -1, -1, "rtype_bad_funct");
        run_instr(6'b000100, 6'h00, 0, 1, -1, "beq_taken");
        run_instr(6'b000100, 6'h00, 0, 0, -1, "beq_not_taken");
        run_instr(6'b001000, 6'h00, 0, -1, -1, "addi");
        run_instr(6'b000010, 6'h00, 0, -1, -1, "j");
        run_instr(6'b111111, 6'h00, 0, -1, -1, "illegal");
        run_instr(6'b000101, 6'h00, 0, 0, -1, "bne_z0");
        run_instr(6'b000101, 6'h00, 0, 1, -1, "bne_z1");

        // Abort lw inside MEMRD (phase index 3), then resume at DECODE on the next edge.
        run_instr(6'b100011, 6'h00, 0, -1, 3, "lw_memrd");
        run_instr(6'b000000, 6'b100100, 1, -1, -1, "after_abort");
        run_instr(6'b101011, 6'h00, 0, -1, 2, "sw_memadr");
        run_instr(6'b101011, 6'h00, 1, -1, -1, "after_abort2");

        for (int n = 0; n < 250; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 6)];
            run_instr(op, fn, 0, -1, -1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
